rsa_prep_mod_shift: RTL and testbench
=====================================

// Module: rsa_prep_mod_shift
// PURPOSE
//   Sequential Montgomery pre-processor for the RSA datapath: computes t_o = (m_i * 2^SHIFT) mod n_i
//   by SHIFT iterations of modular doubling, one iteration per clock.
//   Sits between the key/message loader and the Montgomery multiplier.
//   Generalises the fixed-256-bit pre-processor to any WIDTH/SHIFT, with a clocked FSM and start/finish handshake.
// PARAMETERS
//   WIDTH  256    operand width of n_i, m_i, t_o (>=2)
//   SHIFT  WIDTH  number of doublings, i.e. result = m*2^SHIFT mod n (>=1)
//   CNT_W  $clog2(SHIFT+1)  iteration counter width (derived, do not override)
// PORTS
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request; sampled only in IDLE
//   n_i     in   WIDTH  modulus; captured on accepted start
//   m_i     in   WIDTH  operand; captured on accepted start; precondition m_i < n_i, n_i != 0
//   busy    out  1      high while iterating (state SHIFT)
//   finish  out  1      one-cycle pulse: t_o valid
//   t_o     out  WIDTH  result; holds until next finish
//   err_o   out  1      only with PREP_CHECK_EN (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, busy=0, finish=0, t_o=0, err_o=0, internal regs 0; aborts any run.
//   FSM: IDLE -> SHIFT -> IDLE.
//   IDLE: start=1 at edge k -> n_reg<=n_i, acc<=m_i, cnt<=0, state<=SHIFT. start=0 -> stay.
//   SHIFT: every edge: d = {acc,1'b0} (WIDTH+1 bits, no truncation);
//     acc <= (d >= {1'b0,n_reg}) ? d - n_reg : d  (>= mandatory; result fits WIDTH bits); cnt <= cnt+1.
//   On the iteration with cnt==SHIFT-1: t_o <= reduced value, finish <= 1, state <= IDLE.
//   Latency: finish high in the cycle after edge k+SHIFT (SHIFT+1 clocks from the start cycle).
//   finish: registered, exactly one cycle; deasserted otherwise.
//   start while busy: ignored; inputs may change freely during SHIFT (captured copies used).
//   start high in the finish cycle: accepted (FSM is IDLE); back-to-back throughput SHIFT+1 clocks.
//   Held start: a new run begins each time the FSM re-enters IDLE.
//   Precondition violation without PREP_CHECK_EN: result undefined, but FSM still finishes after SHIFT iterations.
// CONFIGURATION
//   PREP_CHECK_EN defined: adds err_o port. On accepted start with n_i==0 or m_i>=n_i:
//     no iteration; next edge: t_o<=0, err_o<=1, finish<=1, state stays IDLE (latency 1).
//     err_o is cleared on the next accepted start (valid run) and held otherwise.
//   PREP_CHECK_EN undefined: no err_o port, no comparator on inputs, no checks.
// TESTING
//   WIDTH=8,SHIFT=8: n=13, m=5 -> after 9 clocks finish pulse 1 cycle, t_o=6, busy high exactly 8 cycles.
//   WIDTH=8,SHIFT=8: n=255, m=254 -> t_o=254 (exercises WIDTH+1 carry of doubling).
//   WIDTH=8,SHIFT=8: n=8, m=4 -> t_o=0 (exercises d==n, the >= edge); n=251, m=250 -> t_o=246.
//   Back-to-back: start held high, n=13, m=5 then m=0 -> finish pulses 9 clocks apart, t_o=6 then 0;
//     changing m_i mid-run does not alter the result.
//   Reset mid-run: rst_n=0 at iteration 4 -> busy, finish, t_o immediately 0; next run yields correct result.
//   PREP_CHECK_EN: n=13, m=13 -> finish next cycle, err_o=1, t_o=0; n=0 -> same;
//     following valid run clears err_o.
//   WIDTH=256 default: random m<n odd moduli vs. reference model (m<<256)%n; 1000 vectors, zero mismatches.

Source files
------------

// File: rtl/rsa_prep_mod_shift.sv
// rsa_prep_mod_shift
//   Sequential Montgomery pre-processor: t_o = (m_i * 2^SHIFT) mod n_i, computed as
//   SHIFT modular doublings, one per clock, behind a start/finish handshake.
//   Optional feature macro: PREP_CHECK_EN (adds err_o and an input precondition check).
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request, sampled only while idle
//   n_i     in   WIDTH  modulus, captured on accepted start
//   m_i     in   WIDTH  operand, captured on accepted start (m_i < n_i, n_i != 0)
//   busy    out  1      high while iterating
//   finish  out  1      one-cycle pulse, t_o valid
//   err_o   out  1      PREP_CHECK_EN only: last accepted start violated m_i < n_i / n_i != 0
//   t_o     out  WIDTH  result, held until the next finish
module rsa_prep_mod_shift #(
   parameter int unsigned WIDTH = 256,
   parameter int unsigned SHIFT = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] n_i,
   input  logic [WIDTH-1:0] m_i,
   output logic             busy,
   output logic             finish,
`ifdef PREP_CHECK_EN
   output logic             err_o,
`endif
   output logic [WIDTH-1:0] t_o
);

   localparam int unsigned       CNT_W = $clog2(SHIFT + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(SHIFT - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] n_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             finish_q;
   logic [WIDTH-1:0] t_q;

   // One modular doubling step. The doubled value is WIDTH+1 bits wide; its top bit
   // (the carry out of acc) forces a subtraction, and since the reduced value is < n
   // the WIDTH-bit subtraction below wraps to the exact result.
   logic [WIDTH-1:0] dbl_c;
   logic             carry_c;
   always_comb begin
      dbl_c   = {acc_q[WIDTH-2:0], 1'b0};
      carry_c = acc_q[WIDTH-1];
      acc_d   = dbl_c;
      if (carry_c || (dbl_c >= n_q)) begin
         acc_d = dbl_c - n_q;
      end
   end

`ifdef PREP_CHECK_EN
   logic err_q;
   logic in_bad_c;
   assign in_bad_c = (n_i == '0) || (m_i >= n_i);
   assign err_o    = err_q;
`endif

   // Control FSM with registered outputs and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         n_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         finish_q <= 1'b0;
         t_q      <= '0;
`ifdef PREP_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         finish_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
`ifdef PREP_CHECK_EN
                  // Invalid operands: report immediately without iterating.
                  if (in_bad_c) begin
                     t_q      <= '0;
                     err_q    <= 1'b1;
                     finish_q <= 1'b1;
                  end else
`endif
                  begin
`ifdef PREP_CHECK_EN
                     err_q   <= 1'b0;
`endif
                     n_q     <= n_i;
                     acc_q   <= m_i;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST) begin
                  t_q      <= acc_d;
                  finish_q <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign finish = finish_q;
   assign t_o    = t_q;

endmodule

// File: tb/tb_rsa_prep_mod_shift.sv
// tb_rsa_prep_mod_shift
//   Scoreboard bench for rsa_prep_mod_shift at WIDTH=8, SHIFT=8. The driver pushes the
//   expected result, finish cycle, busy length and error flag for every accepted start;
//   a monitor pops and compares each time finish is seen.
module tb_rsa_prep_mod_shift;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned SHIFT = 8;

   typedef struct {
      logic [WIDTH-1:0] t;
      int               cyc;
      int               bsy;
      logic             err;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] n_i;
   logic [WIDTH-1:0] m_i;
   logic             busy;
   logic             finish;
   logic             err_o;
   logic [WIDTH-1:0] t_o;

   rsa_prep_mod_shift #(.WIDTH(WIDTH), .SHIFT(SHIFT)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .n_i    (n_i),
      .m_i    (m_i),
      .busy   (busy),
      .finish (finish),
`ifdef PREP_CHECK_EN
      .err_o  (err_o),
`endif
      .t_o    (t_o)
   );

`ifndef PREP_CHECK_EN
   assign err_o = 1'b0;
`endif

   always #5 clk = ~clk;

   int   n_checks  = 0;
   int   n_errors  = 0;
   int   cyc       = 0;
   int   fin_count = 0;
   int   busy_cnt  = 0;
   logic prev_fin  = 1'b0;
   exp_t sb_q[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: sample just after the edge, compare each finish against the scoreboard.
   always begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
         busy_cnt = 0;
         prev_fin = 1'b0;
      end else begin
         if (busy) busy_cnt++;
         if (finish) begin
            exp_t e;
            fin_count++;
            check_eq("finish_width", 32'(prev_fin), 0);
            if (sb_q.size() == 0) begin
               check_eq("spurious_finish", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check_eq("t_o", 32'(t_o), 32'(e.t));
               check_eq("finish_cycle", cyc, e.cyc);
               check_eq("busy_cycles", busy_cnt, e.bsy);
`ifdef PREP_CHECK_EN
               check_eq("err_o", 32'(err_o), 32'(e.err));
`endif
            end
            busy_cnt = 0;
         end
         prev_fin = finish;
      end
   end

   function automatic logic [WIDTH-1:0] ref_model(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] m);
      int unsigned prod;
      prod = 32'(m) << SHIFT;
      return WIDTH'(prod % 32'(n));
   endfunction

   task automatic wait_fin(input int target, input int budget);
      int i = 0;
      while (fin_count < target && i < budget) begin
         @(negedge clk);
         i++;
      end
      if (fin_count < target) check_eq("finish_timeout", fin_count, target);
   endtask

   task automatic run(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] m, input bit poke);
      int tgt;
      @(negedge clk);
      start = 1'b1;
      n_i   = n;
      m_i   = m;
      sb_q.push_back('{t: ref_model(n, m), cyc: cyc + 1 + int'(SHIFT), bsy: int'(SHIFT), err: 1'b0});
      tgt = fin_count + 1;
      @(negedge clk);
      start = 1'b0;
      n_i   = WIDTH'($urandom);
      m_i   = WIDTH'($urandom);
      if (poke) begin
         repeat (2) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_fin(tgt, 3 * int'(SHIFT));
   endtask

`ifdef PREP_CHECK_EN
   task automatic err_run(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] m);
      int tgt;
      @(negedge clk);
      start = 1'b1;
      n_i   = n;
      m_i   = m;
      sb_q.push_back('{t: '0, cyc: cyc + 1, bsy: 0, err: 1'b1});
      tgt = fin_count + 1;
      @(negedge clk);
      start = 1'b0;
      wait_fin(tgt, 3 * int'(SHIFT));
   endtask
`endif

   initial begin
      int k;
      int tgt;
      logic [WIDTH-1:0] rn;
      logic [WIDTH-1:0] rm;

      rst_n = 1'b0;
      start = 1'b0;
      n_i   = '0;
      m_i   = '0;
      repeat (3) @(negedge clk);
      check_eq("reset_busy", 32'(busy), 0);
      check_eq("reset_finish", 32'(finish), 0);
      check_eq("reset_t_o", 32'(t_o), 0);
      check_eq("reset_err_o", 32'(err_o), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed vectors: basic, doubling carry, d == n edge, near-max modulus.
      run(8'd13, 8'd5, 1'b0);
      run(8'd255, 8'd254, 1'b0);
      run(8'd8, 8'd4, 1'b1);
      run(8'd251, 8'd250, 1'b0);

      // Reset mid-run: outputs clear at once, aborted run never finishes.
      @(negedge clk);
      start = 1'b1;
      n_i   = 8'd13;
      m_i   = 8'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midrun_rst_busy", 32'(busy), 0);
      check_eq("midrun_rst_finish", 32'(finish), 0);
      check_eq("midrun_rst_t_o", 32'(t_o), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run(8'd13, 8'd5, 1'b0);

      // Back-to-back with start held; m_i changes during the first run.
      @(negedge clk);
      start = 1'b1;
      n_i   = 8'd13;
      m_i   = 8'd5;
      k     = cyc + 1;
      tgt   = fin_count + 2;
      sb_q.push_back('{t: 8'd6, cyc: k + int'(SHIFT), bsy: int'(SHIFT), err: 1'b0});
      @(negedge clk);
      m_i = 8'd0;
      sb_q.push_back('{t: 8'd0, cyc: k + 2 * int'(SHIFT) + 1, bsy: int'(SHIFT), err: 1'b0});
      wait_fin(tgt, 4 * int'(SHIFT));
      start = 1'b0;

`ifdef PREP_CHECK_EN
      err_run(8'd13, 8'd13);
      err_run(8'd0, 8'd3);
      run(8'd13, 8'd5, 1'b0);
`endif

      // Random legal operands against the reference model.
      for (int i = 0; i < 40; i++) begin
         rn = WIDTH'($urandom_range(255, 1));
         rm = WIDTH'($urandom_range(int'(rn) - 1, 0));
         run(rn, rm, (i % 3) == 0);
      end

      repeat (3 * SHIFT) @(negedge clk);
      check_eq("scoreboard_empty", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
